// File: rtl/fb_write_ctrlmod_pkg.sv
// Shared frame-buffer definitions: geometry defaults, pixel width and the
// writer FSM encoding. The display read side imports the same package so the
// image geometry cannot diverge between writer and reader.
package fb_write_ctrlmod_pkg;

  localparam int XSIZE_DEF = 128;   // image width in pixels (2**XBITS_DEF)
  localparam int XBITS_DEF = 7;     // log2 of the image width
  localparam int YSIZE_DEF = 96;    // image height in pixels
  localparam int AW_DEF    = 14;    // RAM address width
  localparam int RGB565_W  = 16;    // pixel width in bits

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } fb_state_e;

  // Pixel assembly: the first byte received is the upper half of RGB565.
  function automatic logic [RGB565_W-1:0] rgb565_pack(input logic [7:0] hi,
                                                     input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/fb_write_ctrlmod_if.sv
// Byte-in / RAM-write bus of the frame-buffer writer. The controller is the
// master (it drives RAM port A); the byte source and RAM sit on the slave side.
interface fb_write_ctrlmod_if #(
  parameter int AW = fb_write_ctrlmod_pkg::AW_DEF
);
  import fb_write_ctrlmod_pkg::*;

  logic                iStart;
  logic                iAbort;
  logic [7:0]          iByte;
  logic                iByteValid;
  logic                oWrEn;
  logic [AW-1:0]       oWrAddr;
  logic [RGB565_W-1:0] oWrData;
  logic                oBusy;
  logic                oDone;

  modport master (
    input  iStart, iAbort, iByte, iByteValid,
    output oWrEn, oWrAddr, oWrData, oBusy, oDone
  );

  modport slave (
    output iStart, iAbort, iByte, iByteValid,
    input  oWrEn, oWrAddr, oWrData, oBusy, oDone
  );

endinterface

// File: rtl/fb_write_ctrlmod_xy_counter.sv
// Pixel position tracker: row-major x/y counter with wrap, last-pixel flag
// and the RAM address derived from the current position.
module fb_xy_counter
  import fb_write_ctrlmod_pkg::*;
#(
  parameter int XSIZE = XSIZE_DEF,
  parameter int XBITS = XBITS_DEF,
  parameter int YSIZE = YSIZE_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam int YBITS = (YSIZE > 1) ? $clog2(YSIZE) : 1;

  logic [XBITS-1:0] x_q, x_d;
  logic [YBITS-1:0] y_q, y_d;
  logic             x_end_s, y_end_s;

  // Next position: clear on frame start, advance one pixel per write.
  always_comb begin
    x_end_s = (x_q == XBITS'(XSIZE - 1));
    y_end_s = (y_q == YBITS'(YSIZE - 1));
    x_d     = x_q;
    y_d     = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (inc_i) begin
      if (x_end_s) begin
        x_d = '0;
        // After the final pixel y returns to 0 so the address stays in range.
        if (y_end_s) begin
          y_d = '0;
        end else begin
          y_d = y_q + YBITS'(1);
        end
      end else begin
        x_d = x_q + XBITS'(1);
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Position registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // {y, x} equals (y << XBITS) + x because x never reaches 2**XBITS.
  assign addr_o = AW'({y_q, x_q});
  assign last_o = x_end_s & y_end_s;

endmodule

// File: rtl/fb_write_ctrlmod.sv
// Frame-buffer writer: assembles byte pairs into RGB565 pixels and writes one
// full image into RAM port A, row-major, per start pulse.
module fb_write_ctrlmod
  import fb_write_ctrlmod_pkg::*;
#(
  parameter int XSIZE = XSIZE_DEF,
  parameter int XBITS = XBITS_DEF,
  parameter int YSIZE = YSIZE_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                CLOCK,
  input  logic                RESET,
  fb_write_ctrlmod_if.master  bus
);

  fb_state_e           state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [RGB565_W-1:0] wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cnt_clr_s, cnt_inc_s;
  logic [AW-1:0]       cnt_addr_s;
  logic                cnt_last_s;

  fb_xy_counter #(
    .XSIZE (XSIZE),
    .XBITS (XBITS),
    .YSIZE (YSIZE),
    .AW    (AW)
  ) u_xy (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .clr_i  (cnt_clr_s),
    .inc_i  (cnt_inc_s),
    .addr_o (cnt_addr_s),
    .last_o (cnt_last_s)
  );

  // Next-state, byte latch and write capture; abort wins over everything.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          state_d   = ST_HI;
          hi_d      = 8'h00;
          cnt_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HI: begin
        if (bus.iAbort) begin
          state_d = ST_IDLE;
          hi_d    = 8'h00;
        end else if (bus.iByteValid) begin
          state_d = ST_LO;
          hi_d    = bus.iByte;
        end else begin
          state_d = ST_HI;
        end
      end
      ST_LO: begin
        if (bus.iAbort) begin
          // The pending high byte is dropped with the partial pixel.
          state_d = ST_IDLE;
          hi_d    = 8'h00;
        end else if (bus.iByteValid) begin
          state_d   = ST_WRITE;
          wr_addr_d = cnt_addr_s;
          wr_data_d = rgb565_pack(hi_q, bus.iByte);
        end else begin
          state_d = ST_LO;
        end
      end
      ST_WRITE: begin
        if (bus.iAbort) begin
          state_d = ST_IDLE;
          hi_d    = 8'h00;
        end else begin
          // The counter still points at the pixel being written this cycle.
          cnt_inc_s = 1'b1;
          if (cnt_last_s) begin
            state_d = ST_DONE;
          end else if (bus.iByteValid) begin
            // Back-to-back stream: this strobe is the next pixel's high byte.
            state_d = ST_LO;
            hi_d    = bus.iByte;
          end else begin
            state_d = ST_HI;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        hi_d    = 8'h00;
      end
    endcase
    wr_en_d = (state_d == ST_WRITE);
    busy_d  = (state_d == ST_HI) || (state_d == ST_LO) || (state_d == ST_WRITE);
    done_d  = (state_d == ST_DONE);
  end

  // State and registered output stage.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      hi_q      <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.oWrEn   = wr_en_q;
  assign bus.oWrAddr = wr_addr_q;
  assign bus.oWrData = wr_data_q;
  assign bus.oBusy   = busy_q;
  assign bus.oDone   = done_q;

endmodule

// File: tb/tb_fb_write_ctrlmod.sv
// Directed + randomized bench for the frame-buffer writer. Expected writes are
// derived from the bytes sent: pixel k lands at y*XSIZE+x with x=k%XSIZE,
// y=k/XSIZE, and carries {byte[2k], byte[2k+1]}.
module tb_fb_write_ctrlmod;

  localparam int XS     = 128;
  localparam int YS     = 96;
  localparam int NPIX   = XS * YS;
  localparam int NBYTES = 2 * NPIX;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;

  fb_write_ctrlmod_if #(.AW(14)) bus ();

  fb_write_ctrlmod #(
    .XSIZE (128),
    .XBITS (7),
    .YSIZE (96),
    .AW    (14)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  logic [7:0]  sent_q[$];

  // Write/done monitor, sampled mid-cycle.
  always @(negedge CLOCK) begin
    if (RESET && bus.oWrEn) begin
      addr_q.push_back(32'(bus.oWrAddr));
      data_q.push_back(32'(bus.oWrData));
    end
    if (RESET && bus.oDone) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clr_log();
    addr_q.delete();
    data_q.delete();
    sent_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.iByte      = b;
    bus.iByteValid = 1'b1;
    sent_q.push_back(b);
    tick();
    bus.iByteValid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_start();
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.iAbort = 1'b1;
    tick();
    bus.iAbort = 1'b0;
  endtask

  // Compare every recorded write with the byte-stream model.
  task automatic compare_writes(input string tag);
    int x, y;
    for (int k = 0; k < addr_q.size(); k++) begin
      x = k % XS;
      y = k / XS;
      chk({tag, "_addr"}, addr_q[k], 32'(y * XS + x));
      chk({tag, "_data"}, data_q[k], {16'h0000, sent_q[2*k], sent_q[2*k+1]});
    end
  endtask

  initial begin
    int dc;
    int gap;
    bus.iStart = 1'b0;
    bus.iAbort = 1'b0;
    bus.iByte = 8'h00;
    bus.iByteValid = 1'b0;
    repeat (2) tick();
    RESET = 1'b1;
    tick();

    // Reset state
    chk("rst_wren", 32'(bus.oWrEn), 32'd0);
    chk("rst_busy", 32'(bus.oBusy), 32'd0);
    chk("rst_done", 32'(bus.oDone), 32'd0);
    chk("rst_addr", 32'(bus.oWrAddr), 32'd0);
    chk("rst_data", 32'(bus.oWrData), 32'd0);

    // Bytes in IDLE are ignored
    clr_log();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
    chk("idle_writes", 32'(addr_q.size()), 32'd0);
    chk("idle_busy", 32'(bus.oBusy), 32'd0);
    chk("idle_done", 32'(done_cnt), 32'd0);

    // Single pixel 0xF800 with exact latency
    clr_log();
    pulse_start();
    chk("one_busy_start", 32'(bus.oBusy), 32'd1);
    send_byte(8'hF8, 0);
    chk("one_busy_hi", 32'(bus.oBusy), 32'd1);
    bus.iByte = 8'h00;
    bus.iByteValid = 1'b1;
    chk("one_wren_early", 32'(bus.oWrEn), 32'd0);
    tick();
    bus.iByteValid = 1'b0;
    chk("one_wren", 32'(bus.oWrEn), 32'd1);
    chk("one_addr", 32'(bus.oWrAddr), 32'd0);
    chk("one_data", 32'(bus.oWrData), 32'h0000F800);
    chk("one_busy_wr", 32'(bus.oBusy), 32'd1);
    tick();
    chk("one_wren_pulse", 32'(bus.oWrEn), 32'd0);
    chk("one_busy_after", 32'(bus.oBusy), 32'd1);
    chk("one_hold_data", 32'(bus.oWrData), 32'h0000F800);
    pulse_abort();
    chk("one_abort_busy", 32'(bus.oBusy), 32'd0);

    // Full frame, random data, random 0..2 idle clocks between bytes
    clr_log();
    done_cnt = 0;
    pulse_start();
    for (int i = 0; i < NBYTES; i++) begin
      gap = (i == NBYTES - 1) ? 0 : int'($urandom_range(2, 0));
      send_byte(8'($urandom), gap);
    end
    chk("frame_last_wren", 32'(bus.oWrEn), 32'd1);
    chk("frame_last_addr", 32'(bus.oWrAddr), 32'(NPIX - 1));
    chk("frame_busy_last", 32'(bus.oBusy), 32'd1);
    tick();
    chk("frame_done", 32'(bus.oDone), 32'd1);
    chk("frame_busy_done", 32'(bus.oBusy), 32'd0);
    tick();
    chk("frame_done_pulse", 32'(bus.oDone), 32'd0);
    chk("frame_busy_idle", 32'(bus.oBusy), 32'd0);
    chk("frame_nwrites", 32'(addr_q.size()), 32'(NPIX));
    chk("frame_ndone", 32'(done_cnt), 32'd1);
    chk("frame_row_end", addr_q[127], 32'd127);
    chk("frame_row_next", addr_q[128], 32'd128);
    compare_writes("frame");

    // Back-to-back bytes, one per clock
    clr_log();
    pulse_start();
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'h56, 0); send_byte(8'h78, 0);
    send_byte(8'h9A, 0); send_byte(8'hBC, 0);
    repeat (3) tick();
    chk("b2b_nwrites", 32'(addr_q.size()), 32'd3);
    chk("b2b_data1", data_q[1], 32'h00005678);
    compare_writes("b2b");
    pulse_abort();

    // Abort after a lone high byte, then restart at address 0
    clr_log();
    dc = done_cnt;
    pulse_start();
    send_byte(8'h12, 1);
    pulse_abort();
    chk("abort_busy", 32'(bus.oBusy), 32'd0);
    send_byte(8'h34, 1);
    repeat (3) tick();
    chk("abort_nwrites", 32'(addr_q.size()), 32'd0);
    chk("abort_ndone", 32'(done_cnt), 32'(dc));
    clr_log();
    pulse_start();
    send_byte(8'hAB, 1);
    send_byte(8'hCD, 0);
    chk("restart_addr", 32'(bus.oWrAddr), 32'd0);
    chk("restart_data", 32'(bus.oWrData), 32'h0000ABCD);
    tick();
    pulse_abort();

    // iStart mid-frame at pixel 50 is ignored
    clr_log();
    pulse_start();
    for (int i = 0; i < 100; i++) send_byte(8'($urandom), int'($urandom_range(1, 0)));
    pulse_start();
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    repeat (2) tick();
    chk("midstart_nwrites", 32'(addr_q.size()), 32'd51);
    chk("midstart_addr50", addr_q[50], 32'd50);
    chk("midstart_busy", 32'(bus.oBusy), 32'd1);
    compare_writes("midstart");
    pulse_abort();

    // iAbort together with the low-byte strobe: no write
    clr_log();
    dc = done_cnt;
    pulse_start();
    send_byte(8'h55, 1);
    bus.iByte = 8'h66;
    bus.iByteValid = 1'b1;
    bus.iAbort = 1'b1;
    tick();
    bus.iByteValid = 1'b0;
    bus.iAbort = 1'b0;
    chk("abortlo_busy", 32'(bus.oBusy), 32'd0);
    chk("abortlo_wren", 32'(bus.oWrEn), 32'd0);
    repeat (3) tick();
    chk("abortlo_nwrites", 32'(addr_q.size()), 32'd0);
    chk("abortlo_ndone", 32'(done_cnt), 32'(dc));

    // Asynchronous reset mid-frame
    clr_log();
    pulse_start();
    send_byte(8'hDE, 0); send_byte(8'hAD, 1);
    send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    chk("rstmid_pre_wren", 32'(bus.oWrEn), 32'd1);
    chk("rstmid_pre_addr", 32'(bus.oWrAddr), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("rstmid_wren", 32'(bus.oWrEn), 32'd0);
    chk("rstmid_busy", 32'(bus.oBusy), 32'd0);
    chk("rstmid_addr", 32'(bus.oWrAddr), 32'd0);
    chk("rstmid_data", 32'(bus.oWrData), 32'd0);
    chk("rstmid_done", 32'(bus.oDone), 32'd0);
    tick();
    RESET = 1'b1;
    tick();
    clr_log();
    pulse_start();
    send_byte(8'h07, 0);
    send_byte(8'hE0, 0);
    chk("rstmid_restart_addr", 32'(bus.oWrAddr), 32'd0);
    chk("rstmid_restart_data", 32'(bus.oWrData), 32'h000007E0);
    tick();
    pulse_abort();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
